// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
// instr_sequencer: multi-cycle fetch/decode/execute/memory/write-back
// control FSM. It drives the instruction/data memory handshakes, the IR load,
// register-file write and PC write strobes, and counts retired instructions.
module instr_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned RET_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_imem_req,
  input  logic             i_imem_ready,
  output logic             o_ir_load,
  input  logic             i_dec_reg_wr_en,
  input  logic             i_dec_dmem_rd_en,
  input  logic             i_dec_dmem_wr_en,
  input  logic             i_dec_halt,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  input  logic             i_dmem_ready,
  output logic             o_rf_wr_en,
  output logic             o_pc_wr_en,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_error,
  output logic [RET_W-1:0] o_retired
);

  localparam int unsigned TO_W      = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned TO_LAST_I = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LAST_I);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q;
  logic             reg_wr_q, rd_q, wr_q;
  logic [RET_W-1:0] retired_q;
  logic             timeout_hit;
  logic             req_waiting;

  // The counter holds the number of unanswered request cycles already spent,
  // so it equals MEM_TIMEOUT-1 during the last cycle a ready is accepted.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (to_cnt_q == TO_LAST);
  assign req_waiting = ((state_q == S_FETCH) && !i_imem_ready) ||
                       ((state_q == S_MEM)   && !i_dmem_ready);

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (i_start) state_d = S_FETCH;
      S_FETCH: begin
        if (i_imem_ready)     state_d = S_DECODE;
        else if (timeout_hit) state_d = S_ERROR;
      end
      S_DECODE: state_d = i_dec_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (rd_q && wr_q)      state_d = S_ERROR;
        else if (rd_q || wr_q) state_d = S_MEM;
        else                   state_d = S_WB;
      end
      S_MEM: begin
        if (i_dmem_ready)     state_d = S_WB;
        else if (timeout_hit) state_d = S_ERROR;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase
  end

  // Timeout counter, decoded-flag latches and retired counter
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      to_cnt_q  <= '0;
      reg_wr_q  <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      if (((state_d == S_FETCH) && (state_q != S_FETCH)) ||
          ((state_d == S_MEM)   && (state_q != S_MEM)))
        to_cnt_q <= '0;
      else if (req_waiting && (MEM_TIMEOUT != 0) && !timeout_hit)
        to_cnt_q <= to_cnt_q + TO_W'(1);

      if (state_q == S_DECODE) begin
        reg_wr_q <= i_dec_reg_wr_en;
        rd_q     <= i_dec_dmem_rd_en;
        wr_q     <= i_dec_dmem_wr_en;
      end

      if (state_q == S_WB)
        retired_q <= retired_q + RET_W'(1);
    end
  end

  // Moore outputs from registered state
  always_comb begin
    o_imem_req = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_rf_wr_en = 1'b0;
    o_pc_wr_en = 1'b0;
    o_busy     = 1'b0;
    o_halted   = 1'b0;
    o_error    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        o_imem_req = 1'b1;
        o_busy     = 1'b1;
      end
      S_DECODE, S_EXEC: o_busy = 1'b1;
      S_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = wr_q;
        o_busy     = 1'b1;
      end
      S_WB: begin
        o_pc_wr_en = 1'b1;
        o_rf_wr_en = reg_wr_q && !wr_q;
        o_busy     = 1'b1;
      end
      S_HALT:  o_halted = 1'b1;
      S_ERROR: o_error  = 1'b1;
      default: ;
    endcase
  end

  assign o_ir_load = (state_q == S_FETCH) && i_imem_ready;
  assign o_retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
// tb_instr_sequencer: each instruction is described at transaction level
// (kind, fetch wait, data wait) and expanded into its expected per-cycle
// output schedule. Two DUTs share the stimulus; the second has a 4-bit
// retired counter so counter wrap-around is observed in the same run.
module tb_instr_sequencer;

  localparam int TO = 15;

  logic i_clk = 1'b0;
  logic i_rst, i_start, i_imem_ready, i_dmem_ready;
  logic i_dec_reg_wr_en, i_dec_dmem_rd_en, i_dec_dmem_wr_en, i_dec_halt;

  logic a_imem_req, a_ir_load, a_dmem_req, a_dmem_we, a_rf_wr_en, a_pc_wr_en;
  logic a_busy, a_halted, a_error;
  logic [31:0] a_retired;
  logic b_imem_req, b_ir_load, b_dmem_req, b_dmem_we, b_rf_wr_en, b_pc_wr_en;
  logic b_busy, b_halted, b_error;
  logic [3:0] b_retired;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned ret_model = 0;

  instr_sequencer #(.MEM_TIMEOUT(TO), .RET_W(32)) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .o_imem_req(a_imem_req), .i_imem_ready(i_imem_ready), .o_ir_load(a_ir_load),
    .i_dec_reg_wr_en(i_dec_reg_wr_en), .i_dec_dmem_rd_en(i_dec_dmem_rd_en),
    .i_dec_dmem_wr_en(i_dec_dmem_wr_en), .i_dec_halt(i_dec_halt),
    .o_dmem_req(a_dmem_req), .o_dmem_we(a_dmem_we), .i_dmem_ready(i_dmem_ready),
    .o_rf_wr_en(a_rf_wr_en), .o_pc_wr_en(a_pc_wr_en), .o_busy(a_busy),
    .o_halted(a_halted), .o_error(a_error), .o_retired(a_retired)
  );

  instr_sequencer #(.MEM_TIMEOUT(TO), .RET_W(4)) u_dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .o_imem_req(b_imem_req), .i_imem_ready(i_imem_ready), .o_ir_load(b_ir_load),
    .i_dec_reg_wr_en(i_dec_reg_wr_en), .i_dec_dmem_rd_en(i_dec_dmem_rd_en),
    .i_dec_dmem_wr_en(i_dec_dmem_wr_en), .i_dec_halt(i_dec_halt),
    .o_dmem_req(b_dmem_req), .o_dmem_we(b_dmem_we), .i_dmem_ready(i_dmem_ready),
    .o_rf_wr_en(b_rf_wr_en), .o_pc_wr_en(b_pc_wr_en), .o_busy(b_busy),
    .o_halted(b_halted), .o_error(b_error), .o_retired(b_retired)
  );

  always #5 i_clk = ~i_clk;

  // Expected output vector: {imem_req, ir_load, dmem_req, dmem_we, rf_wr, pc_wr, busy, halted, error}
  function automatic logic [8:0] ev(input bit imq, irl, dmq, dwe, rfw, pcw, bsy, hlt, err);
    return {imq, irl, dmq, dwe, rfw, pcw, bsy, hlt, err};
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0]  oa, ob;
    logic [31:0] ra_exp;
    logic [3:0]  rb_exp;
    oa = {a_imem_req, a_ir_load, a_dmem_req, a_dmem_we, a_rf_wr_en, a_pc_wr_en, a_busy, a_halted, a_error};
    ob = {b_imem_req, b_ir_load, b_dmem_req, b_dmem_we, b_rf_wr_en, b_pc_wr_en, b_busy, b_halted, b_error};
    ra_exp = ret_model;
    rb_exp = ret_model[3:0];
    tests++;
    assert (oa === exp) else begin
      fails++; $error("FAIL %s outs_a observed=%b expected=%b", tag, oa, exp);
    end
    tests++;
    assert (ob === exp) else begin
      fails++; $error("FAIL %s outs_b observed=%b expected=%b", tag, ob, exp);
    end
    tests++;
    assert (a_retired === ra_exp) else begin
      fails++; $error("FAIL %s retired_a observed=%0d expected=%0d", tag, a_retired, ra_exp);
    end
    tests++;
    assert (b_retired === rb_exp) else begin
      fails++; $error("FAIL %s retired_b observed=%0d expected=%0d", tag, b_retired, rb_exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample 1 ns later
  task automatic step(input string tag, input bit st, imr, dmr, rw, rd, wr, hl,
                      input logic [8:0] exp);
    @(negedge i_clk);
    i_start = st; i_imem_ready = imr; i_dmem_ready = dmr;
    i_dec_reg_wr_en = rw; i_dec_dmem_rd_en = rd; i_dec_dmem_wr_en = wr; i_dec_halt = hl;
    #1;
    check(tag, exp);
  endtask

  // Fetch: ready arrives in request cycle wait_n (0-based); no ready within TO cycles -> timeout
  task automatic fetch(input int wait_n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < TO && !ok; c++) begin
      if (c == wait_n) begin
        step("fetch_rdy", rb(), 1'b1, rb(), rb(), rb(), rb(), rb(), ev(1,1,0,0,0,0,1,0,0));
        ok = 1'b1;
      end else begin
        step("fetch_wait", rb(), 1'b0, rb(), rb(), rb(), rb(), rb(), ev(1,0,0,0,0,0,1,0,0));
      end
    end
  endtask

  task automatic mem(input int wait_n, input bit we, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < TO && !ok; c++) begin
      if (c == wait_n) begin
        step("mem_rdy", rb(), rb(), 1'b1, rb(), rb(), rb(), rb(), ev(0,0,1,we,0,0,1,0,0));
        ok = 1'b1;
      end else begin
        step("mem_wait", rb(), rb(), 1'b0, rb(), rb(), rb(), rb(), ev(0,0,1,we,0,0,1,0,0));
      end
    end
  endtask

  // Runs one instruction starting in FETCH; outcome 0 = retired, 1 = halted, 2 = error
  task automatic instr(input bit rw, rd, wr, hl, input int iw, dw, output int outcome);
    bit ok;
    outcome = 2;
    fetch(iw, ok);
    if (ok) begin
      step("decode", rb(), rb(), rb(), rw, rd, wr, hl, ev(0,0,0,0,0,0,1,0,0));
      if (hl) begin
        outcome = 1;
      end else begin
        step("exec", rb(), rb(), rb(), rb(), rb(), rb(), rb(), ev(0,0,0,0,0,0,1,0,0));
        if (!(rd && wr)) begin
          if (rd || wr) mem(dw, wr, ok);
          if (ok) begin
            step("wb", rb(), rb(), rb(), rb(), rb(), rb(), rb(), ev(0,0,0,0,rw && !wr,1,1,0,0));
            ret_model++;
            outcome = 0;
          end
        end
      end
    end
  endtask

  task automatic run_random(input int n);
    int kind, outcome;
    bit rw, rd, wr;
    for (int i = 0; i < n; i++) begin
      kind = int'($urandom_range(0, 2));
      rw = rb();
      rd = (kind == 1);
      wr = (kind == 2);
      instr(rw, rd, wr, 1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), outcome);
    end
  endtask

  task automatic terminal(input string tag, input logic [8:0] exp, input int n);
    for (int i = 0; i < n; i++)
      step(tag, 1'b1, rb(), rb(), rb(), rb(), rb(), rb(), exp);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b0; i_start = 1'b1; i_imem_ready = rb(); i_dmem_ready = rb();
    #1;
    ret_model = 0;
    check("reset", ev(0,0,0,0,0,0,0,0,0));
    @(posedge i_clk); #1;
    check("reset_hold", ev(0,0,0,0,0,0,0,0,0));
  endtask

  // Release reset; optionally idle one cycle first, then present start in IDLE
  task automatic begin_run(input bit idle_first);
    @(negedge i_clk);
    i_rst = 1'b1;
    if (idle_first) begin
      i_start = 1'b0; i_imem_ready = 1'b1; i_dmem_ready = 1'b1; #1;
      check("idle_hold", ev(0,0,0,0,0,0,0,0,0));
      @(negedge i_clk);
    end
    i_start = 1'b1; i_imem_ready = rb(); i_dmem_ready = rb(); #1;
    check("idle_start", ev(0,0,0,0,0,0,0,0,0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int outcome;
    bit ok;
    i_rst = 1'b0; i_start = 1'b0; i_imem_ready = 1'b0; i_dmem_ready = 1'b0;
    i_dec_reg_wr_en = 1'b0; i_dec_dmem_rd_en = 1'b0; i_dec_dmem_wr_en = 1'b0; i_dec_halt = 1'b0;

    // add, load with 3 data wait cycles, store, then enough to wrap the 4-bit counter
    do_reset();
    begin_run(1'b1);
    instr(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, outcome);
    instr(1'b1, 1'b1, 1'b0, 1'b0, 0, 3, outcome);
    instr(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, outcome);
    run_random(14);
    run_random(6);
    instr(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, outcome);
    terminal("err_rdwr", ev(0,0,0,0,0,0,0,0,1), 4);

    // fetch timeout: ready never arrives
    do_reset();
    begin_run(1'b0);
    fetch(TO, ok);
    terminal("err_ifetch_to", ev(0,0,0,0,0,0,0,0,1), 4);

    // ready in the last allowed fetch cycle, then halt after 3 retired
    do_reset();
    begin_run(1'b0);
    instr(1'b0, 1'b0, 1'b0, 1'b0, TO - 1, 0, outcome);
    run_random(2);
    instr(1'b0, 1'b0, 1'b0, 1'b1, 1, 0, outcome);
    terminal("halted", ev(0,0,0,0,0,0,0,1,0), 5);

    // asynchronous reset in the middle of a data request
    do_reset();
    begin_run(1'b0);
    run_random(2);
    fetch(0, ok);
    step("decode_ld", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,0,1,0,0));
    step("exec_ld", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,1,0,0));
    step("mem_pre_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,1,0,0,0,1,0,0));
    #2;
    i_rst = 1'b0;
    #1;
    ret_model = 0;
    check("async_rst", ev(0,0,0,0,0,0,0,0,0));

    // data ready in last allowed cycle, then data timeout
    do_reset();
    begin_run(1'b0);
    instr(1'b0, 1'b0, 1'b1, 1'b0, 0, TO - 1, outcome);
    instr(1'b1, 1'b1, 1'b0, 1'b0, 0, TO, outcome);
    terminal("err_dmem_to", ev(0,0,0,0,0,0,0,0,1), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
